// File: rtl/rv_pkg.sv
// Shared types and constants for the integer register-file slice.
package rv_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ZERO     = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: x0/range check, write-back bypass and busy lookup.
module regfile_sb_rdport
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             run_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic [XLEN-1:0]  regs_i [NREGS],
  input  logic [NREGS-1:0] pending_i,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             rd_busy_o
);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) != REG_ZERO) && (int'(a) < NREGS);
  endfunction

  // Port mux: zero while scrubbing or for x0/out-of-range, bypass beats storage.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (!run_i || !addr_ok(rd_addr_i)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else if (wb_valid_i && (wb_addr_i == rd_addr_i)) begin
      rd_data_o = wb_data_i;
      rd_busy_o = 1'b0;
    end else begin
      rd_data_o = regs_i[rd_addr_i];
      rd_busy_o = pending_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard, write-back bypass and a
// one-entry-per-cycle scrub after every reset.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_addr_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              init_done_o
);

  localparam logic [AW-1:0]    CNT_LAST = AW'(NREGS - 1);
  localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

  rf_state_t        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [XLEN-1:0]  regs_q [NREGS];

  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [XLEN-1:0]  wdata_s;
  logic             wb_ok_s, iss_ok_s;
  logic [NREGS-1:0] wb_mask_s, iss_mask_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) != REG_ZERO) && (int'(a) < NREGS);
  endfunction

  assign wb_ok_s    = wb_valid_i && addr_ok(wb_addr_i);
  assign iss_ok_s   = issue_valid_i && addr_ok(issue_addr_i);
  assign wb_mask_s  = wb_ok_s  ? (ONE_HOT0 << wb_addr_i)    : '0;
  assign iss_mask_s = iss_ok_s ? (ONE_HOT0 << issue_addr_i) : '0;

  // Next state: scrub sequencing in CLEAR; scoreboard and storage writes in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    we_s      = 1'b0;
    waddr_s   = cnt_q;
    wdata_s   = '0;
    case (state_q)
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cnt_q;
        wdata_s = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        we_s      = wb_ok_s;
        waddr_s   = wb_addr_i;
        wdata_s   = wb_data_i;
        // Issue is OR-ed after the clear so a same-cycle re-issue keeps the bit set.
        pending_d = (pending_q & ~wb_mask_s) | iss_mask_s;
      end
      default: begin
        state_d   = CLEAR;
        cnt_d     = '0;
        pending_d = '0;
      end
    endcase
  end

  // Control state: FSM, scrub counter and pending vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Storage array; contents are cleared by the scrub rather than by reset.
  always_ff @(posedge clk) begin
    if (!reset && we_s) begin
      regs_q[waddr_s] <= wdata_s;
    end
  end

  assign init_done_o = (state_q == RUN);

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .run_i      (state_q == RUN),
      .rd_addr_i  (rd_addr_i[p*AW +: AW]),
      .wb_valid_i (wb_valid_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .regs_i     (regs_q),
      .pending_i  (pending_q),
      .rd_data_o  (rd_data_o[p*XLEN +: XLEN]),
      .rd_busy_o  (rd_busy_o[p])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized run
// compared against an array/counter model of the register file.
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 wb_valid;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 init_done;
  logic [AW-1:0]        ra [NRD];

  always_comb begin
    rd_addr = '0;
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = ra[p];
  end

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_busy_o     (rd_busy),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .init_done_o   (init_done)
  );

  // Reference model: register values, pending bits, edges left in the scrub.
  logic [XLEN-1:0]  mreg [NREGS];
  logic [NREGS-1:0] mpend;
  int               left;
  int               n_cmp = 0;
  int               n_mis = 0;

  function automatic bit m_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (left != 0 || !m_ok(a)) return '0;
    if (wb_valid && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (left != 0 || !m_ok(a)) return 1'b0;
    if (wb_valid && wb_addr == a) return 1'b0;
    return mpend[a];
  endfunction

  task automatic set_in(input bit r, input bit iv, input int ia, input bit wv,
                        input int wa, input logic [XLEN-1:0] wd, input int a0, input int a1);
    reset = r; issue_valid = iv; issue_addr = AW'(ia);
    wb_valid = wv; wb_addr = AW'(wa); wb_data = wd;
    ra[0] = AW'(a0); ra[1] = AW'(a1);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      left = NREGS;
      mpend = '0;
      for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    end else if (left > 0) begin
      left--;
    end else begin
      if (wb_valid && m_ok(wb_addr)) begin
        mreg[wb_addr] = wb_data;
        mpend[wb_addr] = 1'b0;
      end
      if (issue_valid && m_ok(issue_addr)) mpend[issue_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    set_in(1'b1, 1'b1, 4, 1'b1, 5, 64'h1234, 5, 7);
    tick();
    tick();
    n_cmp++;
    if (init_done !== 1'b0) begin n_mis++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    for (int p = 0; p < NRD; p++) begin
      n_cmp++;
      if (rd_data[p*XLEN +: XLEN] !== 64'h0 || rd_busy[p] !== 1'b0) begin
        n_mis++; $display("FAIL reset_read p%0d: got %h/%b expected 0/0", p, rd_data[p*XLEN +: XLEN], rd_busy[p]);
      end
    end
    // Scrub with write-back noise that must be ignored.
    for (int i = 0; i < NREGS; i++) begin
      set_in(1'b0, 1'b1, i, 1'b1, i, rnd64(), i, 31 - i);
      n_cmp++;
      if (init_done !== 1'b0 || rd_data !== '0) begin
        n_mis++; $display("FAIL scrub_edge%0d: got done=%b data=%h expected 0/0", i, init_done, rd_data);
      end
      tick();
    end
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 3, 31);
    n_cmp++;
    if (init_done !== 1'b1) begin n_mis++; $display("FAIL scrub_done: got %b expected 1", init_done); end
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin n_mis++; $display("FAIL scrub_zero: got %h/%b expected 0/0", rd_data, rd_busy); end
  endtask

  task automatic test_preload_rescrub();
    set_in(1'b0, 1'b0, 0, 1'b1, 5, 64'hDEAD, 5, 0);
    n_cmp++;
    if (rd_data[XLEN-1:0] !== 64'hDEAD) begin n_mis++; $display("FAIL preload_bypass: got %h expected dead", rd_data[XLEN-1:0]); end
    tick();
    set_in(1'b1, 1'b0, 0, 1'b0, 0, '0, 5, 0);
    tick();
    for (int i = 0; i < NREGS; i++) begin
      set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 5, 0);
      n_cmp++;
      if (init_done !== 1'b0) begin n_mis++; $display("FAIL rescrub_edge%0d: got %b expected 0", i, init_done); end
      tick();
    end
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 5, 5);
    n_cmp++;
    if (init_done !== 1'b1 || rd_data[XLEN-1:0] !== 64'h0) begin
      n_mis++; $display("FAIL rescrub_reg5: got done=%b data=%h expected 1/0", init_done, rd_data[XLEN-1:0]);
    end
  endtask

  task automatic test_basic();
    set_in(1'b0, 1'b0, 0, 1'b1, 7, 64'h0123_4567_89AB_CDEF, 7, 6);
    n_cmp++;
    if (rd_data[XLEN-1:0] !== 64'h0123_4567_89AB_CDEF || rd_busy[0] !== 1'b0) begin
      n_mis++; $display("FAIL basic_bypass: got %h/%b expected 0123456789abcdef/0", rd_data[XLEN-1:0], rd_busy[0]);
    end
    tick();
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 7, 7);
    for (int p = 0; p < NRD; p++) begin
      n_cmp++;
      if (rd_data[p*XLEN +: XLEN] !== 64'h0123_4567_89AB_CDEF) begin
        n_mis++; $display("FAIL basic_stored p%0d: got %h expected 0123456789abcdef", p, rd_data[p*XLEN +: XLEN]);
      end
    end
    tick();
  endtask

  task automatic test_x0();
    set_in(1'b0, 1'b1, 0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin n_mis++; $display("FAIL x0_same: got %h/%b expected 0/0", rd_data, rd_busy); end
    tick();
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 0, 0);
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin n_mis++; $display("FAIL x0_next: got %h/%b expected 0/0", rd_data, rd_busy); end
    tick();
  endtask

  task automatic test_scoreboard();
    set_in(1'b0, 1'b1, 3, 1'b0, 0, '0, 3, 3);
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_mis++; $display("FAIL sb_issue_cycle: got %b expected 00", rd_busy); end
    tick();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 3, 3);
      n_cmp++;
      if (rd_busy !== 2'b11) begin n_mis++; $display("FAIL sb_busy_n%0d: got %b expected 11", k, rd_busy); end
      tick();
    end
    set_in(1'b0, 1'b0, 0, 1'b1, 3, 64'h42, 3, 3);
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_data !== {64'h42, 64'h42}) begin
      n_mis++; $display("FAIL sb_wb_bypass: got %h/%b expected 42/00", rd_data, rd_busy);
    end
    tick();
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 3, 3);
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_data !== {64'h42, 64'h42}) begin
      n_mis++; $display("FAIL sb_retired: got %h/%b expected 42/00", rd_data, rd_busy);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    set_in(1'b0, 1'b1, 9, 1'b1, 9, 64'h11, 9, 9);
    tick();
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 9, 9);
    n_cmp++;
    if (rd_data !== {64'h11, 64'h11} || rd_busy !== 2'b11) begin
      n_mis++; $display("FAIL same_cycle: got %h/%b expected 11/11", rd_data, rd_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    set_in(1'b1, 1'b0, 0, 1'b0, 0, '0, 1, 2);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b0, 0, 1'b1, 1 + i, rnd64(), 1, 2);
      tick();
    end
    set_in(1'b1, 1'b0, 0, 1'b0, 0, '0, 1, 2);
    tick();
    for (int i = 0; i < NREGS; i++) begin
      set_in(1'b0, 1'b1, 1 + (i % 2), 1'b1, 1 + (i % 2), rnd64(), 1, 2);
      n_cmp++;
      if (init_done !== 1'b0) begin n_mis++; $display("FAIL midclear_edge%0d: got %b expected 0", i, init_done); end
      tick();
    end
    set_in(1'b0, 1'b0, 0, 1'b0, 0, '0, 1, 2);
    n_cmp++;
    if (init_done !== 1'b1 || rd_data !== '0 || rd_busy !== '0) begin
      n_mis++; $display("FAIL midclear_after: got done=%b data=%h busy=%b expected 1/0/0", init_done, rd_data, rd_busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_in(($urandom_range(0, 249) == 0), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
             $urandom_range(0, 2) == 0, $urandom_range(0, 7), rnd64(),
             $urandom_range(0, 7), $urandom_range(0, 31));
      n_cmp++;
      if (init_done !== (left == 0)) begin
        n_mis++; $display("FAIL rand_done c%0d: got %b expected %b", c, init_done, left == 0);
      end
      for (int p = 0; p < NRD; p++) begin
        n_cmp++;
        if (rd_data[p*XLEN +: XLEN] !== exp_data(ra[p]) || rd_busy[p] !== exp_busy(ra[p])) begin
          n_mis++;
          $display("FAIL rand_read c%0d p%0d a%0d: got %h/%b expected %h/%b", c, p, ra[p],
                   rd_data[p*XLEN +: XLEN], rd_busy[p], exp_data(ra[p]), exp_busy(ra[p]));
        end
      end
      tick();
    end
  endtask

  initial begin
    left  = NREGS;
    mpend = '0;
    for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    set_in(1'b1, 1'b0, 0, 1'b0, 0, '0, 0, 0);
    @(negedge clk);
    test_reset();
    test_preload_rescrub();
    test_basic();
    test_x0();
    test_scoreboard();
    test_same_cycle();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
